apb_uart_csr: RTL



---
 rtl/apb_uart_pkg.sv | 34 +++
 rtl/apb_uart_csr.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_pkg.sv
// Shared definitions for the UART APB register front end: register offsets,
// field positions, the transfer-state encoding and the CTRL register layout.
package apb_uart_pkg;

    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_BAUD   = 12'h004;
    localparam logic [11:0] OFF_STATUS = 12'h008;
    localparam logic [11:0] OFF_TXDATA = 12'h00C;
    localparam logic [11:0] OFF_RXDATA = 12'h010;
    localparam logic [11:0] OFF_IER    = 12'h014;
    localparam logic [11:0] OFF_ISR    = 12'h018;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_PAR_EN_BIT  = 1;
    localparam int CTRL_PAR_ODD_BIT = 2;
    localparam int CTRL_STOP2_BIT   = 3;
    localparam int ISR_RXV_BIT      = 0;
    localparam int ISR_TXR_BIT      = 1;
    localparam int ISR_OVR_BIT      = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_WAIT = 2'd1,
        RX_WAIT = 2'd2
    } state_t;

    typedef struct packed {
        logic stop2;
        logic par_odd;
        logic par_en;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/apb_uart_csr.sv
// APB slave register file for the UART; bridges TXDATA/RXDATA to the core's
// byte streams, stretching the transfer with wait states up to WAIT_MAX cycles.
module apb_uart_csr
    import apb_uart_pkg::*;
#(
    parameter int          ADDR_W     = 12,
    parameter int          DATA_W     = 32,
    parameter int          WAIT_MAX   = 16,
    parameter logic [15:0] BAUD_RESET = 16'd54
) (
    input  logic              clk,
    input  logic              preset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [3:0]        pstrb,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              tx_busy,
    input  logic              rx_overrun,
    output logic              ctrl_en,
    output logic              ctrl_par_en,
    output logic              ctrl_par_odd,
    output logic              ctrl_stop2,
    output logic [15:0]       baud_div,
    output logic              irq
);

    localparam logic [4:0] CNT_LAST = 5'(WAIT_MAX - 1);

    state_t      state_r, state_nxt_s;
    logic [4:0]  cnt_r, cnt_nxt_s;
    ctrl_t       ctrl_r;
    logic [15:0] baud_r;
    logic [2:0]  ier_r;
    logic        ovr_r;
    logic        irq_r;

    logic        access_s, wr_en_s, ovr_clr_s, err_s;
    logic        sel_ctrl_s, sel_baud_s, sel_status_s, sel_tx_s, sel_rx_s, sel_ier_s, sel_isr_s;
    logic [2:0]  isr_s;
    logic [DATA_W-1:0] rdata_s;
    logic        unused_s;

    assign access_s     = psel & penable;
    assign sel_ctrl_s   = (paddr == ADDR_W'(OFF_CTRL));
    assign sel_baud_s   = (paddr == ADDR_W'(OFF_BAUD));
    assign sel_status_s = (paddr == ADDR_W'(OFF_STATUS));
    assign sel_tx_s     = (paddr == ADDR_W'(OFF_TXDATA));
    assign sel_rx_s     = (paddr == ADDR_W'(OFF_RXDATA));
    assign sel_ier_s    = (paddr == ADDR_W'(OFF_IER));
    assign sel_isr_s    = (paddr == ADDR_W'(OFF_ISR));

    // Any of these completes immediately as an error with no side effect.
    assign err_s = (paddr[1:0] != 2'b00)
                 | ~(sel_ctrl_s | sel_baud_s | sel_status_s | sel_tx_s | sel_rx_s | sel_ier_s | sel_isr_s)
                 | (pwrite & (sel_status_s | sel_rx_s))
                 | (~pwrite & sel_tx_s)
                 | (pwrite & sel_tx_s & ~pstrb[0]);

    assign isr_s     = {ovr_r, tx_ready, rx_valid};
    assign ovr_clr_s = wr_en_s & sel_isr_s & pstrb[0] & pwdata[ISR_OVR_BIT];
    assign unused_s  = ^{pwdata[DATA_W-1:16], pstrb[3:2]};

    // Read mux for the zero-wait registers.
    always_comb begin
        rdata_s = '0;
        if (sel_ctrl_s) begin
            rdata_s[3:0] = ctrl_r;
        end else if (sel_baud_s) begin
            rdata_s[15:0] = baud_r;
        end else if (sel_status_s) begin
            rdata_s[3:0] = {ovr_r, tx_busy, rx_valid, tx_ready};
        end else if (sel_ier_s) begin
            rdata_s[2:0] = ier_r;
        end else if (sel_isr_s) begin
            rdata_s[2:0] = isr_s;
        end else begin
            rdata_s = '0;
        end
    end

    // Transfer FSM next state and combinational bus/stream outputs.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        pready      = 1'b0;
        pslverr     = 1'b0;
        prdata      = '0;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;
        rx_ready    = 1'b0;
        wr_en_s     = 1'b0;
        if (preset) begin
            state_nxt_s = IDLE;
            cnt_nxt_s   = 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!access_s) begin
                        state_nxt_s = IDLE;
                    end else if (err_s) begin
                        pready  = 1'b1;
                        pslverr = 1'b1;
                    end else if (sel_tx_s) begin
                        if (tx_ready) begin
                            tx_valid = 1'b1;
                            tx_data  = pwdata[7:0];
                            pready   = 1'b1;
                        end else begin
                            state_nxt_s = TX_WAIT;
                            cnt_nxt_s   = 5'd0;
                        end
                    end else if (sel_rx_s) begin
                        if (rx_valid) begin
                            rx_ready    = 1'b1;
                            prdata[7:0] = rx_data;
                            pready      = 1'b1;
                        end else begin
                            state_nxt_s = RX_WAIT;
                            cnt_nxt_s   = 5'd0;
                        end
                    end else begin
                        pready  = 1'b1;
                        wr_en_s = pwrite;
                        prdata  = pwrite ? '0 : rdata_s;
                    end
                end
                TX_WAIT: begin
                    if (!psel) begin
                        state_nxt_s = IDLE;
                    end else if (tx_ready) begin
                        tx_valid    = 1'b1;
                        tx_data     = pwdata[7:0];
                        pready      = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        pready      = 1'b1;
                        pslverr     = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + 5'd1;
                    end
                end
                RX_WAIT: begin
                    if (!psel) begin
                        state_nxt_s = IDLE;
                    end else if (rx_valid) begin
                        rx_ready    = 1'b1;
                        prdata[7:0] = rx_data;
                        pready      = 1'b1;
                        state_nxt_s = IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        pready      = 1'b1;
                        pslverr     = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        cnt_nxt_s = cnt_r + 5'd1;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 5'd0;
                end
            endcase
        end
    end

    // State, register file, sticky overrun flag and registered interrupt.
    always_ff @(posedge clk) begin
        if (preset) begin
            state_r <= IDLE;
            cnt_r   <= 5'd0;
            ctrl_r  <= '0;
            baud_r  <= BAUD_RESET;
            ier_r   <= 3'b000;
            ovr_r   <= 1'b0;
            irq_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (wr_en_s && sel_ctrl_s && pstrb[0]) ctrl_r <= ctrl_t'(pwdata[3:0]);
            if (wr_en_s && sel_baud_s && pstrb[0]) baud_r[7:0] <= pwdata[7:0];
            if (wr_en_s && sel_baud_s && pstrb[1]) baud_r[15:8] <= pwdata[15:8];
            if (wr_en_s && sel_ier_s && pstrb[0]) ier_r <= pwdata[2:0];
            // A new overrun in the same cycle as the clear must not be lost.
            if (rx_overrun) begin
                ovr_r <= 1'b1;
            end else if (ovr_clr_s) begin
                ovr_r <= 1'b0;
            end
            irq_r <= |(ier_r & isr_s);
        end
    end

    assign ctrl_en      = ctrl_r.en;
    assign ctrl_par_en  = ctrl_r.par_en;
    assign ctrl_par_odd = ctrl_r.par_odd;
    assign ctrl_stop2   = ctrl_r.stop2;
    assign baud_div     = baud_r;
    assign irq          = irq_r;

endmodule
